// File: rtl/ecdsa_sign_arbiter.sv
// ecdsa_sign_arbiter: round-robin owner selection for one shared ECDSA
// signing core, with nonce fetch, bounded retry and result capture.
// Optional per-attempt watchdog enabled by defining ECDSA_ARB_TIMEOUT_EN;
// when undefined the arbiter waits indefinitely for TRNG and core.
//
// state   | meaning
// IDLE    | no job; wait for a request while the core is ready
// ARB     | round-robin pick of the next owner, latch grant/sel
// NONCE   | strobe trng_req once, wait for trng_valid
// BUSY    | core_go high, wait for core_done
// CHECK   | core_go high, sample core_failure, capture r/s
// DRAIN   | core_go low, wait for core_ready
// RESP    | one-cycle rsp_valid to the owner, advance rr pointer
// RECOVER | pulse core_rst, count retry, retry or give up
module ecdsa_sign_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int KEY_SIZE       = 256,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] sel,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic                       rsp_fail,
   output logic [KEY_SIZE-1:0]        r_out,
   output logic [KEY_SIZE-1:0]        s_out,
   output logic                       core_go,
   output logic                       core_rst,
   input  logic                       core_ready,
   input  logic                       core_done,
   input  logic                       core_failure,
   input  logic [KEY_SIZE-1:0]        core_r,
   input  logic [KEY_SIZE-1:0]        core_s,
   output logic                       trng_req,
   input  logic                       trng_valid
);

   localparam int SEL_W = $clog2(NUM_REQ);
   localparam int RC_W  = $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {
      IDLE, ARB, NONCE, BUSY, CHECK, DRAIN, RESP, RECOVER
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [RC_W-1:0]     retry_q, retry_d;
   logic [KEY_SIZE-1:0] r_q, r_d;
   logic [KEY_SIZE-1:0] s_q, s_d;
   logic                fail_q, fail_d;
   logic                trng_first_q, trng_first_d;

   logic                pick_found;
   logic [SEL_W-1:0]    pick_idx;
   logic [SEL_W-1:0]    scan_idx;

`ifdef ECDSA_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0]     wd_q, wd_d;
`endif

   // Round-robin search: first requester at or after rr_ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = SEL_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!pick_found && req[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   // Next-state and job bookkeeping.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      retry_d  = retry_q;
      r_d      = r_q;
      s_d      = s_q;
      fail_d   = fail_q;
      case (state_q)
         IDLE: if ((|req) && core_ready) state_d = ARB;
         ARB: begin
            if (pick_found) begin
               sel_d             = pick_idx;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               retry_d           = '0;
               fail_d            = 1'b0;
               state_d           = NONCE;
            end else begin
               // requester withdrew before arbitration; nothing to serve
               state_d = IDLE;
            end
         end
         NONCE: if (trng_valid) state_d = BUSY;
         BUSY:  if (core_done) state_d = CHECK;
         CHECK: begin
            if (core_failure) begin
               state_d = RECOVER;
            end else begin
               r_d     = core_r;
               s_d     = core_s;
               state_d = DRAIN;
            end
         end
         DRAIN: if (core_ready) state_d = RESP;
         RESP: begin
            rr_ptr_d = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
            grant_d  = '0;
            state_d  = IDLE;
         end
         RECOVER: begin
            retry_d = retry_q + 1'b1;
            if (retry_q == RC_W'(MAX_RETRY - 1)) begin
               fail_d  = 1'b1;
               r_d     = '0;
               s_d     = '0;
               state_d = RESP;
            end else begin
               state_d = NONCE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef ECDSA_ARB_TIMEOUT_EN
      wd_d = wd_q;
      if (state_q inside {NONCE, BUSY, CHECK, DRAIN}) begin
         wd_d = wd_q + 1'b1;
         // watchdog expiry overrides whatever the attempt was doing
         if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) state_d = RECOVER;
      end
      if ((state_d == NONCE) && (state_q != NONCE)) wd_d = '0;
`endif
      trng_first_d = (state_d == NONCE) && (state_q != NONCE);
   end

   // State and job registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         sel_q        <= '0;
         rr_ptr_q     <= '0;
         retry_q      <= '0;
         r_q          <= '0;
         s_q          <= '0;
         fail_q       <= 1'b0;
         trng_first_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         sel_q        <= sel_d;
         rr_ptr_q     <= rr_ptr_d;
         retry_q      <= retry_d;
         r_q          <= r_d;
         s_q          <= s_d;
         fail_q       <= fail_d;
         trng_first_q <= trng_first_d;
      end
   end

`ifdef ECDSA_ARB_TIMEOUT_EN
   // Per-attempt watchdog counter.
   always_ff @(posedge clk) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`endif

   // Outputs decode from registered state only.
   assign grant     = grant_q;
   assign sel       = sel_q;
   assign core_go   = (state_q == BUSY) || (state_q == CHECK);
   assign core_rst  = (state_q == RECOVER);
   assign trng_req  = (state_q == NONCE) && trng_first_q;
   assign rsp_valid = (state_q == RESP) ? grant_q : '0;
   assign rsp_fail  = (state_q == RESP) && fail_q;
   assign r_out     = r_q;
   assign s_out     = s_q;

endmodule

// File: tb/tb_ecdsa_sign_arbiter.sv
// Bench for ecdsa_sign_arbiter: behavioural signing core and TRNG, a
// round-robin/retry reference model, directed and randomized jobs.
`timescale 1ns/1ps
module tb_ecdsa_sign_arbiter;
   localparam int NR = 4;
   localparam int KW = 256;
   localparam int MR = 3;
`ifdef ECDSA_ARB_TIMEOUT_EN
   localparam int TMO      = 50;
   localparam int LAT_LONG = 30;
`else
   localparam int TMO      = 65535;
   localparam int LAT_LONG = 100;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req, grant, rsp_valid;
   logic [1:0]    sel;
   logic          rsp_fail;
   logic [KW-1:0] r_out, s_out, core_r, core_s;
   logic          core_go, core_rst, core_ready, core_done, core_failure;
   logic          trng_req, trng_valid;

   always #5 clk = ~clk;

   ecdsa_sign_arbiter #(
      .NUM_REQ(NR), .KEY_SIZE(KW), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel),
      .rsp_valid(rsp_valid), .rsp_fail(rsp_fail), .r_out(r_out), .s_out(s_out),
      .core_go(core_go), .core_rst(core_rst), .core_ready(core_ready),
      .core_done(core_done), .core_failure(core_failure),
      .core_r(core_r), .core_s(core_s),
      .trng_req(trng_req), .trng_valid(trng_valid)
   );

   // behavioural core / TRNG configuration
   int            core_lat  = 10;
   int            drain_lat = 1;
   int            trng_lat  = 1;
   logic [7:0]    fail_mask = '0;
   int            attempt   = 0;
   bit            fixed_rs  = 1'b0;
   logic [KW-1:0] last_r = '0, last_s = '0;
   bit            c_busy, c_hold;
   int            c_cnt, d_cnt, t_cnt;

   function automatic logic [KW-1:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Core and TRNG model, driven on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         c_busy = 0; c_hold = 0; c_cnt = 0; d_cnt = 0; t_cnt = 0;
         core_ready = 1; core_done = 0; core_failure = 0;
         core_r = '0; core_s = '0; trng_valid = 0;
      end else begin
         trng_valid = 0;
         if (trng_req) t_cnt = trng_lat;
         else if (t_cnt > 0) begin
            t_cnt--;
            if (t_cnt == 0) trng_valid = 1;
         end
         core_done = 0;
         if (core_rst) begin
            c_busy = 0; c_hold = 0; d_cnt = 0; core_ready = 1;
         end else if (c_busy) begin
            c_cnt--;
            if (c_cnt == 0) begin
               c_busy = 0; c_hold = 1; core_done = 1;
               core_failure = fail_mask[attempt % 8];
               core_r = fixed_rs ? KW'(5) : rand_key();
               core_s = fixed_rs ? KW'(7) : rand_key();
               last_r = core_r; last_s = core_s;
               attempt++;
            end
         end else if (c_hold) begin
            if (!core_go) begin c_hold = 0; d_cnt = drain_lat; end
         end else if (d_cnt > 0) begin
            d_cnt--;
            if (d_cnt == 0) core_ready = 1;
         end else if (core_go) begin
            c_busy = 1; c_cnt = core_lat; core_ready = 0;
         end
      end
   end

   int vectors = 0, miscompares = 0;
   int ptr_m = 0;
   int n_rst, n_trng, multi_grant, grant_moves, cyc = 0, last_trng_cyc = 0;
   int tmo_delta[$];
   logic [NR-1:0] obs_valid;
   logic [1:0]    obs_sel;
   logic          obs_fail;
   logic [KW-1:0] obs_r, obs_s;
   bit            hold_req = 1'b0;

   task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration: first set request at or after p, wrapping.
   function automatic int pick(input logic [NR-1:0] r, input int p);
      for (int k = 0; k < NR; k++) begin
         int j = (p + k) % NR;
         if (((r >> j) & 1) != 0) return j;
      end
      return -1;
   endfunction

   task automatic wait_rsp(input string tag, input int budget, input int drop_at);
      logic [NR-1:0] g0 = '0;
      bit got = 0;
      n_rst = 0; n_trng = 0; multi_grant = 0; grant_moves = 0;
      tmo_delta.delete();
      obs_valid = '0; obs_sel = '0; obs_fail = 0; obs_r = '0; obs_s = '0;
      for (int c = 0; c < budget && !got; c++) begin
         @(negedge clk);
         cyc++;
         if (c == drop_at) req = '0;
         if (trng_req) begin n_trng++; last_trng_cyc = cyc; end
         if (core_rst) begin n_rst++; tmo_delta.push_back(cyc - last_trng_cyc); end
         if ($countones(grant) > 1) multi_grant++;
         if (grant != '0) begin
            if (g0 == '0) g0 = grant;
            else if (grant != g0) grant_moves++;
         end
         if (rsp_valid != '0) begin
            got = 1;
            obs_valid = rsp_valid; obs_sel = sel; obs_fail = rsp_fail;
            obs_r = r_out; obs_s = s_out;
            if (!hold_req) req = req & ~rsp_valid;
         end
      end
      if (!got) begin
         vectors++; miscompares++;
         $error("FAIL %s.timeout observed=no_rsp expected=rsp_within_%0d", tag, budget);
      end
   endtask

   // One job: predict owner/attempts/result from the model, then compare.
   task automatic run_job(input string tag, input logic [7:0] mask, input bit fx, input int drop_at);
      int k = 0;
      int owner;
      bit exp_fail;
      logic [KW-1:0] er, es;
      owner = pick(req, ptr_m);
      fail_mask = mask; attempt = 0; fixed_rs = fx;
      while (k < MR && mask[k]) k++;
      exp_fail = (k == MR);
      wait_rsp(tag, 1000, drop_at);
      er = exp_fail ? '0 : (fx ? KW'(5) : last_r);
      es = exp_fail ? '0 : (fx ? KW'(7) : last_s);
      check({tag, ".rsp_valid"}, obs_valid, KW'(1) << owner);
      check({tag, ".sel"}, obs_sel, owner);
      check({tag, ".rsp_fail"}, obs_fail, exp_fail);
      check({tag, ".r_out"}, obs_r, er);
      check({tag, ".s_out"}, obs_s, es);
      check({tag, ".core_rst_pulses"}, n_rst, exp_fail ? MR : k);
      check({tag, ".trng_req_pulses"}, n_trng, exp_fail ? MR : k + 1);
      check({tag, ".multi_grant"}, multi_grant, 0);
      check({tag, ".grant_moved"}, grant_moves, 0);
      ptr_m = (owner + 1) % NR;
      @(negedge clk);
      cyc++;
      check({tag, ".after_resp"}, {grant, rsp_valid}, 0);
   endtask

   initial begin
      bit seen;
      int strays;
      rst = 1; req = '0;
      repeat (3) @(negedge clk);
      check("reset.ctl", {grant, sel, rsp_valid, rsp_fail, core_go, core_rst, trng_req}, 0);
      check("reset.r", r_out, 0);
      check("reset.s", s_out, 0);
      rst = 0;
      @(negedge clk);

      // four requesters held: strict rotation 0,1,2,3,0
      hold_req = 1; req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         core_lat = $urandom_range(1, 12);
         run_job($sformatf("rr%0d", j), 8'h00, 1'b0, -1);
         check($sformatf("rr%0d.order", j), ptr_m, (j + 1) % NR);
      end
      hold_req = 0; req = '0;
      repeat (2) @(negedge clk);

      // single requester, long core latency, fixed result
      core_lat = LAT_LONG; req = 4'b0001;
      run_job("basic", 8'h00, 1'b1, -1);

      // two failed attempts then success; all attempts fail
      core_lat = 8; req = 4'b0010;
      run_job("retry2", 8'h03, 1'b0, -1);
      req = 4'b1000;
      run_job("allfail", 8'h07, 1'b0, -1);

      // requester withdraws mid-job: response still delivered
      req = 4'b0001;
      run_job("withdraw", 8'h00, 1'b0, 6);

`ifdef ECDSA_ARB_TIMEOUT_EN
      // core never finishes: watchdog recovers every attempt
      core_lat = 1000; req = 4'b0100;
      run_job("watchdog", 8'hFF, 1'b0, -1);
      check("watchdog.deltas", tmo_delta.size(), MR);
      foreach (tmo_delta[i]) check($sformatf("watchdog.delta%0d", i), tmo_delta[i], TMO);
      core_lat = 8;
`endif

      // randomized jobs
      for (int j = 0; j < 12; j++) begin
         req = req | NR'($urandom_range(1, 15));
         core_lat  = $urandom_range(1, 20);
         drain_lat = $urandom_range(1, 3);
         trng_lat  = $urandom_range(1, 4);
         run_job($sformatf("rand%0d", j), 8'($urandom_range(0, 7)), 1'b0, -1);
      end
      req = '0; drain_lat = 1; trng_lat = 1;
      repeat (2) @(negedge clk);

      // leave rr_ptr at 3, then reset mid-job
      req = 4'b0100;
      run_job("pre_rst", 8'h00, 1'b0, -1);
      core_lat = 40; req = 4'b0010; fail_mask = '0; attempt = 0;
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (core_go) seen = 1;
      end
      check("rst.reached_busy", seen, 1);
      rst = 1; req = '0;
      @(negedge clk);
      check("rst.ctl", {grant, sel, rsp_valid, rsp_fail, core_go, core_rst, trng_req}, 0);
      check("rst.r", r_out, 0);
      check("rst.s", s_out, 0);
      rst = 0; ptr_m = 0; core_lat = 8;
      strays = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid != '0) strays++;
      end
      check("rst.dropped_job", strays, 0);
      req = 4'b1001;
      run_job("post_rst0", 8'h00, 1'b0, -1);
      run_job("post_rst1", 8'h00, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard stop in case a wait loop is bypassed by a broken design.
   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end
endmodule
